// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue and writeback bundle for alu_issue_ctrl.
//   master : instruction source; drives in_*, observes in_ready and wb_*
//   slave  : the controller; accepts in_*, drives in_ready and wb_*
// Ports carried:
//   in_valid/in_ready handshake, in_load, in_op[2:0], in_rd/in_rs1/in_rs2[AW],
//   in_imm[DW], wb_valid, wb_rd[AW], wb_data[DW], wb_ext
interface alu_issue_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_load;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [DW-1:0] in_imm;

  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_ext;

  modport master (
    output in_valid, in_load, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_ext
  );

  modport slave (
    input  in_valid, in_load, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, wb_valid, wb_rd, wb_data, wb_ext
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around an external 4-bit combinational ALU.
// Holds a small operand register file, accepts register-addressed
// instructions, registers operands/opcode into the ALU, captures the
// (DW+1)-bit result one cycle later and writes it back.
// Ports:
//   clk, rst         : clock, async active-high reset
//   bus (slave)      : instruction handshake and writeback strobe
//   alu_a, alu_b     : registered operands to the ALU
//   alu_opcode       : registered opcode to the ALU
//   alu_result       : combinational ALU result
//   busy             : controller not idle
//   retired          : wrapping count of completed instructions
//
// state | meaning
// IDLE  | ready for an instruction; operands are read here
// EXEC  | ALU inputs stable; result captured at the end of the cycle
// WB    | register write, wb_valid asserted next cycle, retired++
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_ctrl_if.slave bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [DW:0]   alu_result,
  output logic          busy,
  output logic [CW-1:0] retired
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q;
  state_t        state_d;
  logic          accept;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] rd_q;
  logic [DW:0]   res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          // loads need no ALU pass, so they skip EXEC
          state_d = bus.in_load ? WB : EXEC;
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.wb_ext   <= 1'b0;
      retired      <= '0;
    end else begin
      bus.wb_valid <= 1'b0;

      if (accept) begin
        rd_q <= bus.in_rd;
        if (bus.in_load) begin
          res_q <= {1'b0, bus.in_imm};
        end else begin
          alu_a      <= regs[bus.in_rs1];
          alu_b      <= regs[bus.in_rs2];
          alu_opcode <= bus.in_op;
        end
      end

      if (state_q == EXEC) res_q <= alu_result;

      // The write lands on the same edge that returns to IDLE, so the next
      // instruction's operand read already sees it.
      if (state_q == WB) begin
        regs[rd_q]   <= res_q[DW-1:0];
        bus.wb_valid <= 1'b1;
        bus.wb_rd    <= rd_q;
        bus.wb_data  <= res_q[DW-1:0];
        bus.wb_ext   <= res_q[DW];
        retired      <= retired + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int DW   = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_opcode;
  logic [DW:0]   alu_result;
  logic          busy;
  logic [CW-1:0] retired;

  alu_issue_ctrl_if #(.AW(AW), .DW(DW)) bus();

  alu_issue_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .busy       (busy),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: plain integer arithmetic truncated to 5 bits.
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [2:0] op);
    int r;
    case (op)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = 15 - int'(a);
      3'd5:    r = int'(a) * int'(b);
      3'd6:    r = int'(a ^ b);
      default: r = 15 - int'(a ^ b);
    endcase
    return r[DW:0];
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          ext;
    logic [CW-1:0] ret;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            wb_count = 0;
  logic [DW-1:0] mregs [NREG];
  int            mret     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.wb_valid === 1'b1) begin
      wb_count++;
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd",      32'(bus.wb_rd),   32'(e.rd));
        chk("wb_data",    32'(bus.wb_data), 32'(e.data));
        chk("wb_ext",     32'(bus.wb_ext),  32'(e.ext));
        chk("wb_retired", 32'(retired),     32'(e.ret));
        chk("wb_latency", 32'(cyc),         32'(e.due));
      end
    end
  end

  task automatic check_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd",    32'(bus.wb_rd),    32'd0);
    chk("rst_wb_data",  32'(bus.wb_data),  32'd0);
    chk("rst_wb_ext",   32'(bus.wb_ext),   32'd0);
    chk("rst_alu_a",    32'(alu_a),        32'd0);
    chk("rst_alu_b",    32'(alu_b),        32'd0);
    chk("rst_alu_op",   32'(alu_opcode),   32'd0);
    chk("rst_retired",  32'(retired),      32'd0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mret = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset();
  endtask

  // Presents an instruction (in_valid stays high on return). When track=0
  // the instruction is expected to be abandoned and is not modelled.
  task automatic issue(input bit ld, input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm, input bit track = 1'b1);
    int            n = 0;
    logic [DW:0]   r;
    logic [DW-1:0] a_exp;
    logic [DW-1:0] b_exp;
    exp_t          e;
    bus.in_valid = 1'b1;
    bus.in_load  = ld;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("issue_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    a_exp = mregs[rs1];
    b_exp = mregs[rs2];
    if (track) begin
      r = ld ? {1'b0, imm} : alu_fn(a_exp, b_exp, op);
      mregs[rd] = r[DW-1:0];
      mret = (mret + 1) % (1 << CW);
      e.rd   = rd;
      e.data = r[DW-1:0];
      e.ext  = r[DW];
      e.ret  = CW'(mret);
      e.due  = cyc + (ld ? 2 : 3);
      sb.push_back(e);
    end
    @(negedge clk);
    chk("busy_after_hs",  32'(busy),         32'd1);
    chk("ready_after_hs", 32'(bus.in_ready), 32'd0);
    if (!ld) begin
      chk("exec_alu_a",  32'(alu_a),      32'(a_exp));
      chk("exec_alu_b",  32'(alu_b),      32'(b_exp));
      chk("exec_alu_op", 32'(alu_opcode), 32'(op));
    end
  endtask

  task automatic idle(input int k);
    bus.in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_load  = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    @(negedge clk);
    do_reset();

    // Directed: loads, add with carry, sub borrow, mul overflow.
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7);
    idle(2);
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    issue(1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 4'd0);
    issue(1'b0, 3'd5, 2'd3, 2'd0, 2'd1, 4'd0);
    drain();

    // Dependent back-to-back with in_valid held high.
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3);
    issue(1'b0, 3'd0, 2'd1, 2'd0, 2'd0, 4'd0);
    issue(1'b0, 3'd6, 2'd2, 2'd2, 2'd2, 4'd0);
    drain();

    // Reset during EXEC abandons the add; registers then read as zero.
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd7);
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0);
    do_reset();
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    issue(1'b0, 3'd3, 2'd3, 2'd2, 2'd3, 4'd0);
    drain();

    // Randomized mix with random gaps.
    for (int i = 0; i < 80; i++) begin
      issue($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), AW'($urandom),
            AW'($urandom), AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    drain();

    // 256 loads wrap the retired counter.
    do_reset();
    w0 = wb_count;
    for (int i = 0; i < 256; i++) issue(1'b1, 3'd0, AW'($urandom), 2'd0, 2'd0, DW'($urandom));
    drain();
    chk("wrap_retired",  32'(retired),       32'd0);
    chk("wrap_wb_count", 32'(wb_count - w0), 32'd256);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
